// File: rtl/wlo_cmd_pkg.sv
// Shared constants and types for the word-length-optimisation command initiator.
package wlo_cmd_pkg;

  localparam logic [7:0]  HDR_BYTE  = 8'hA5;
  localparam int unsigned MSE_BYTES = 8;

  typedef enum logic [1:0] {
    OpRsvd     = 2'd0,
    OpWriteCfg = 2'd1,
    OpStart    = 2'd2,
    OpSoftRst  = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StSendHdr,
    StSendOp,
    StSendPay,
    StWaitResp
  } init_state_t;

endpackage

// File: rtl/wlo_cmd_initiator_if.sv
// Command, byte-stream and result signals between a host and the initiator.
interface wlo_cmd_initiator_if #(
  parameter int unsigned NUM_CHAN = 30
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [NUM_CHAN*8-1:0] cfg_int;
  logic [NUM_CHAN*8-1:0] cfg_frac;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic [63:0]           mse_data;
  logic                  mse_valid;
  logic                  busy;
  logic                  err_timeout;

  // Initiator side.
  modport master (
    input  cmd_valid, cmd_op, cfg_int, cfg_frac, tx_ready, rx_valid, rx_data,
    output cmd_ready, tx_valid, tx_data, mse_data, mse_valid, busy, err_timeout
  );

  // Host / harness side.
  modport slave (
    output cmd_valid, cmd_op, cfg_int, cfg_frac, tx_ready, rx_valid, rx_data,
    input  cmd_ready, tx_valid, tx_data, mse_data, mse_valid, busy, err_timeout
  );

endinterface

// File: rtl/mse_byte_collector.sv
// Collects the MSB-first MSE response bytes and watches the inter-byte gap.
module mse_byte_collector
  import wlo_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2**24
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        arm,       // entering the response wait: reload everything
  input  logic        active,    // currently waiting for response bytes
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        clr_err,
  output logic        done,      // final byte is being taken this cycle
  output logic        expired,   // gap limit reached this cycle
  output logic [63:0] mse_data,
  output logic        mse_valid,
  output logic        err_timeout
);

  localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned AccW   = (MSE_BYTES - 1) * 8;

  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [63:0]       mse_q, mse_d;
  logic              mse_valid_q, mse_valid_d;
  logic              err_q, err_d;

  // Next-state for accumulator, byte counter, gap timer and result flags.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_q;
    timer_d     = timer_q;
    mse_d       = mse_q;
    mse_valid_d = 1'b0;
    err_d       = err_q;
    done        = active && rx_valid && (byte_cnt_q == 3'(MSE_BYTES - 1));
    expired     = active && !rx_valid && (timer_q == TimerW'(TIMEOUT_CYC - 1));

    if (arm) begin
      byte_cnt_d = '0;
      acc_d      = '0;
      timer_d    = '0;
    end else if (active) begin
      if (rx_valid) begin
        timer_d    = '0;
        acc_d      = {acc_q[AccW-9:0], rx_data};
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (done) begin
          mse_d       = {acc_q, rx_data};
          mse_valid_d = 1'b1;
        end
      end else if (expired) begin
        // Partial response is thrown away; the previous result stays visible.
        err_d      = 1'b1;
        acc_d      = '0;
        byte_cnt_d = '0;
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end

    if (clr_err) err_d = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt_q  <= '0;
      acc_q       <= '0;
      timer_q     <= '0;
      mse_q       <= '0;
      mse_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      timer_q     <= timer_d;
      mse_q       <= mse_d;
      mse_valid_q <= mse_valid_d;
      err_q       <= err_d;
    end
  end

  assign mse_data    = mse_q;
  assign mse_valid   = mse_valid_q;
  assign err_timeout = err_q;

endmodule

// File: rtl/wlo_cmd_initiator.sv
// Host-side initiator: frames commands into bytes and gathers the MSE response.
module wlo_cmd_initiator
  import wlo_cmd_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = 30,
  parameter int unsigned TIMEOUT_CYC = 2**24
) (
  input  logic clk,
  input  logic rstn,
  wlo_cmd_initiator_if.master bus
);

  localparam int unsigned PayLen = 2 * NUM_CHAN;
  localparam int unsigned IdxW   = $clog2(PayLen);
  localparam int unsigned CfgW   = NUM_CHAN * 8;

  init_state_t     state_q, state_d;
  cmd_op_t         op_q, op_d;
  logic [CfgW-1:0] int_q, int_d;
  logic [CfgW-1:0] frac_q, frac_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ch;
  logic [7:0]      pay_byte;
  logic            accept;
  logic            arm;
  logic            active;
  logic            done;
  logic            expired;
  logic            tx_valid;
  logic [7:0]      tx_data;

  // Payload byte select: even index is the int byte, odd the frac byte of channel idx/2.
  always_comb begin
    ch       = idx_q >> 1;
    pay_byte = 8'h00;
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      if (ch == IdxW'(k)) pay_byte = idx_q[0] ? frac_q[k*8 +: 8] : int_q[k*8 +: 8];
    end
  end

  // Frame FSM next-state and byte mux.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    int_d    = int_q;
    frac_d   = frac_q;
    idx_d    = idx_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    arm      = 1'b0;
    accept   = (state_q == StIdle) && bus.cmd_valid;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d   = cmd_op_t'(bus.cmd_op);
          int_d  = bus.cfg_int;
          frac_d = bus.cfg_frac;
          idx_d  = '0;
          // Reserved opcode is swallowed without a frame.
          if (cmd_op_t'(bus.cmd_op) != OpRsvd) state_d = StSendHdr;
        end
      end
      StSendHdr: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (bus.tx_ready) state_d = StSendOp;
      end
      StSendOp: begin
        tx_valid = 1'b1;
        tx_data  = {6'd0, op_q};
        if (bus.tx_ready) begin
          unique case (op_q)
            OpWriteCfg: state_d = StSendPay;
            OpStart: begin
              state_d = StWaitResp;
              arm     = 1'b1;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StSendPay: begin
        tx_valid = 1'b1;
        tx_data  = pay_byte;
        if (bus.tx_ready) begin
          if (idx_q == IdxW'(PayLen - 1)) state_d = StIdle;
          else                            idx_d   = idx_q + IdxW'(1);
        end
      end
      StWaitResp: begin
        if (done || expired) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and latched command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      op_q    <= OpRsvd;
      int_q   <= '0;
      frac_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      idx_q   <= idx_d;
    end
  end

  assign active = (state_q == StWaitResp);

  mse_byte_collector #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_collector (
    .clk         (clk),
    .rstn        (rstn),
    .arm         (arm),
    .active      (active),
    .rx_valid    (bus.rx_valid),
    .rx_data     (bus.rx_data),
    .clr_err     (accept),
    .done        (done),
    .expired     (expired),
    .mse_data    (bus.mse_data),
    .mse_valid   (bus.mse_valid),
    .err_timeout (bus.err_timeout)
  );

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;

endmodule

// File: tb/tb_wlo_cmd_initiator.sv
// Directed bench for wlo_cmd_initiator: vector table plus multi-cycle sequences.
module tb_wlo_cmd_initiator;
  import wlo_cmd_pkg::*;

  localparam int unsigned NCH = 30;
  localparam int unsigned TO  = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wlo_cmd_initiator_if #(.NUM_CHAN(NCH)) bus ();

  wlo_cmd_initiator #(
    .NUM_CHAN    (NCH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  int         checks     = 0;
  int         errors     = 0;
  int         mse_pulses = 0;
  int         hold_viol  = 0;
  bit         hold_pend  = 1'b0;
  logic [7:0] hold_byte  = 8'h00;
  logic [7:0] txq[$];

  // Byte monitor at the inactive edge: handshakes, hold stability, result pulses.
  always @(negedge clk) begin
    if (hold_pend && bus.tx_valid && (bus.tx_data !== hold_byte)) hold_viol <= hold_viol + 1;
    hold_pend <= bus.tx_valid && !bus.tx_ready;
    hold_byte <= bus.tx_data;
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    if (bus.mse_valid) mse_pulses <= mse_pulses + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg();
    for (int k = 0; k < NCH; k++) begin
      bus.cfg_int[k*8 +: 8]  = 8'd2;
      bus.cfg_frac[k*8 +: 8] = 8'(k);
    end
  endtask

  task automatic issue(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input bit rand_ready, input int maxc);
    bit ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.tx_ready = 1'b1;
    chk("idle_reached", 64'(ok), 64'd1);
  endtask

  task automatic wait_frame(input int nbytes, input logic [7:0] opb);
    for (int n = 0; n < 100 && txq.size() < nbytes; n++) tick();
    chk("frame_len", 64'(txq.size()), 64'(nbytes));
    if (txq.size() >= 2) begin
      chk("frame_hdr", 64'(txq[0]), 64'hA5);
      chk("frame_op", 64'(txq[1]), 64'(opb));
    end
  endtask

  // Drive the 8 response bytes MSB first with a fixed spacing and check completion.
  task automatic send_resp(input logic [63:0] resp, input int gap);
    int p0 = mse_pulses;
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = resp[63-8*i -: 8];
      tick();
      bus.rx_valid = 1'b0;
      if (i < 7) repeat (gap - 1) tick();
    end
    chk("mse_valid_pulse", 64'(bus.mse_valid), 64'd1);
    chk("mse_data", bus.mse_data, resp);
    chk("busy_after_resp", 64'(bus.busy), 64'd0);
    tick();
    chk("mse_valid_drop", 64'(bus.mse_valid), 64'd0);
    chk("mse_pulse_count", 64'(mse_pulses - p0), 64'd1);
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    bit         rand_ready;
    int         exp_len;
  } vec_t;

  vec_t vecs[4];
  int   n;
  int   p0;

  initial begin
    vecs[0] = '{"soft_rst",  2'd3, 1'b0, 2};
    vecs[1] = '{"write_cfg", 2'd1, 1'b0, 62};
    vecs[2] = '{"wcfg_rand", 2'd1, 1'b1, 62};
    vecs[3] = '{"reserved",  2'd0, 1'b0, 0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.tx_ready  = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    set_cfg();

    // Reset state.
    repeat (2) tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mse_data", bus.mse_data, 64'd0);
    chk("rst_mse_valid", 64'(bus.mse_valid), 64'd0);
    chk("rst_err", 64'(bus.err_timeout), 64'd0);
    rstn = 1'b1;
    tick();

    // START with a slow responder.
    txq.delete();
    issue(2'd2);
    chk("start_tx_valid_rise", 64'(bus.tx_valid), 64'd1);
    wait_frame(2, 8'h02);
    send_resp(64'h0123456789ABCDEF, 10);

    // Table of framed commands.
    foreach (vecs[v]) begin
      txq.delete();
      set_cfg();
      issue(vecs[v].op);
      // Input changes after acceptance must not leak into the frame.
      bus.cfg_int  = '1;
      bus.cfg_frac = '1;
      if (vecs[v].op != 2'd0) chk({vecs[v].name, "_tx_rise"}, 64'(bus.tx_valid), 64'd1);
      else                    chk({vecs[v].name, "_ready"}, 64'(bus.cmd_ready), 64'd1);
      run_until_idle(vecs[v].rand_ready, 2000);
      repeat (3) tick();
      chk({vecs[v].name, "_len"}, 64'(txq.size()), 64'(vecs[v].exp_len));
      if (txq.size() >= 2 && vecs[v].exp_len >= 2) begin
        chk({vecs[v].name, "_hdr"}, 64'(txq[0]), 64'hA5);
        chk({vecs[v].name, "_op"}, 64'(txq[1]), {62'd0, vecs[v].op});
      end
      if (vecs[v].op == 2'd1 && txq.size() >= 62) begin
        for (int i = 0; i < 60; i++) begin
          chk($sformatf("%s_pay%0d", vecs[v].name, i), 64'(txq[2+i]),
              (i % 2 == 0) ? 64'd2 : 64'(i / 2));
        end
      end
      chk({vecs[v].name, "_mse_kept"}, bus.mse_data, 64'h0123456789ABCDEF);
    end
    chk("hold_stable", 64'(hold_viol), 64'd0);

    // Timeout after a truncated response.
    set_cfg();
    txq.delete();
    p0 = mse_pulses;
    issue(2'd2);
    wait_frame(2, 8'h02);
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hAA + 8'(i);
      tick();
    end
    bus.rx_valid = 1'b0;
    for (n = 1; n <= 200; n++) begin
      tick();
      if (bus.err_timeout) break;
    end
    chk("timeout_cycles", 64'(n), 64'd64);
    chk("timeout_err", 64'(bus.err_timeout), 64'd1);
    chk("timeout_busy", 64'(bus.busy), 64'd0);
    chk("timeout_mse_kept", bus.mse_data, 64'h0123456789ABCDEF);
    chk("timeout_no_pulse", 64'(mse_pulses - p0), 64'd0);
    txq.delete();
    issue(2'd3);
    chk("softrst_clears_err", 64'(bus.err_timeout), 64'd0);
    run_until_idle(1'b0, 50);
    chk("softrst_len", 64'(txq.size()), 64'd2);
    if (txq.size() >= 2) chk("softrst_op", 64'(txq[1]), 64'h03);

    // Reset in the middle of a WRITE_CFG payload.
    txq.delete();
    issue(2'd1);
    for (int c = 0; c < 100 && txq.size() < 12; c++) tick();
    rstn = 1'b0;
    tick();
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("midrst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_mse_data", bus.mse_data, 64'd0);
    chk("midrst_err", 64'(bus.err_timeout), 64'd0);
    rstn = 1'b1;
    tick();
    chk("midrst_no_resume", 64'(bus.busy), 64'd0);
    txq.delete();
    issue(2'd2);
    wait_frame(2, 8'h02);
    send_resp(64'hFEDCBA9876543210, 1);

    // Commands while busy are dropped; idle rx bytes are not stored.
    txq.delete();
    issue(2'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    repeat (3) tick();
    bus.cmd_valid = 1'b0;
    wait_frame(2, 8'h02);
    send_resp(64'h1122334455667788, 2);
    p0 = mse_pulses;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    tick();
    bus.rx_valid = 1'b0;
    repeat (5) tick();
    chk("busy_no_extra_frame", 64'(txq.size()), 64'd2);
    chk("spurious_mse_kept", bus.mse_data, 64'h1122334455667788);
    chk("spurious_no_pulse", 64'(mse_pulses - p0), 64'd0);
    chk("spurious_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
